// File: rtl/time_setup_editor_pkg.sv
// chasy_setup_pkg: editor state type, default setup mode/field limits, modulo field step helpers
package chasy_setup_pkg;
  typedef enum logic [1:0] {IDLE, EDIT, COMMIT, DONE} setup_state_t;
  localparam logic [1:0] SETUP_MODE = 2'd3;
  localparam logic [23:0] DEF_FIELD_MAX = {8'd23, 8'd59, 8'd59};
  // Values above the limit wrap to 0 on the first increment.
  function automatic logic [31:0] wrap_inc(input logic [31:0] v, input logic [31:0] m);
    return v >= m ? 32'd0 : v + 32'd1;
  endfunction
  function automatic logic [31:0] wrap_dec(input logic [31:0] v, input logic [31:0] m);
    return v == 32'd0 ? m : v - 32'd1;
  endfunction
endpackage

// File: rtl/time_setup_editor_if.sv
// time_setup_editor_if: mode, buttons and running time in; edit buffer, field select, editing, commit pulse out
// master drives rezhim/btn_next/btn_inc/btn_dec/time_in; slave (the editor) drives setup_data/field_sel/editing/setup_imp
interface time_setup_editor_if #(
  parameter int NUM_FIELDS = 3,
  parameter int FIELD_W = 8
);
  localparam int SEL_W = NUM_FIELDS > 1 ? $clog2(NUM_FIELDS) : 1;
  logic [1:0] rezhim;
  logic btn_next;
  logic btn_inc;
  logic btn_dec;
  logic [NUM_FIELDS*FIELD_W-1:0] time_in;
  logic [NUM_FIELDS*FIELD_W-1:0] setup_data;
  logic [SEL_W-1:0] field_sel;
  logic editing;
  logic setup_imp;
  modport master (
    output rezhim, btn_next, btn_inc, btn_dec, time_in,
    input setup_data, field_sel, editing, setup_imp
  );
  modport slave (
    input rezhim, btn_next, btn_inc, btn_dec, time_in,
    output setup_data, field_sel, editing, setup_imp
  );
endinterface

// File: rtl/time_setup_editor_btn_step_gen.sv
// btn_step_gen: one step pulse per rising edge of a debounced button, plus hold auto-repeat under SETUP_AUTOREPEAT_EN
// ports: clock, reset, btn (level), clr (suppress step and cancel repeat), step (pulse)
module btn_step_gen
`ifdef SETUP_AUTOREPEAT_EN
#(
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_PERIOD = 10
)
`endif
(
  input  logic clock,
  input  logic reset,
  input  logic btn,
  input  logic clr,
  output logic step
);
  logic btn_q, btn_d, rise;
  assign btn_d = btn;
  assign rise = btn & ~btn_q;
  // Reset to 1 so a button held through reset gives no edge until released.
  always_ff @(posedge clock)
    if (reset) btn_q <= 1'b1;
    else btn_q <= btn_d;
`ifdef SETUP_AUTOREPEAT_EN
  localparam int CNT_W = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
  logic rep_q, rep_d, tick;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Down-counter: reaches 0 REPEAT_DELAY cycles after the edge, then every REPEAT_PERIOD.
  always_comb begin
    tick = rep_q & btn & (cnt_q == '0);
    rep_d = btn & ~clr & (rise | rep_q);
    cnt_d = rise ? CNT_W'(REPEAT_DELAY - 1) : tick ? CNT_W'(REPEAT_PERIOD - 1) : cnt_q - CNT_W'(1);
  end
  always_ff @(posedge clock)
    if (reset) begin
      rep_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      rep_q <= rep_d;
      cnt_q <= cnt_d;
    end
  assign step = (rise | tick) & ~clr;
`else
  assign step = rise & ~clr;
`endif
endmodule

// File: rtl/time_setup_editor.sv
// time_setup_editor: multi-field time edit buffer loaded on setup entry, button-driven edit, one-cycle commit pulse
// ports: clock, reset (sync, active-high), bus (time_setup_editor_if.slave); optional auto-repeat: SETUP_AUTOREPEAT_EN
module time_setup_editor
  import chasy_setup_pkg::*;
#(
  parameter int NUM_FIELDS = 3,
  parameter int FIELD_W = 8,
  parameter logic [NUM_FIELDS*FIELD_W-1:0] FIELD_MAX = DEF_FIELD_MAX,
  parameter logic [1:0] SETUP_MODE = chasy_setup_pkg::SETUP_MODE
`ifdef SETUP_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_PERIOD = 10
`endif
) (
  input logic clock,
  input logic reset,
  time_setup_editor_if.slave bus
);
  localparam int W = NUM_FIELDS * FIELD_W;
  localparam int SEL_W = NUM_FIELDS > 1 ? $clog2(NUM_FIELDS) : 1;
  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_FIELDS - 1);
  setup_state_t state_q, state_d;
  logic [W-1:0] data_q, data_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic editing_q, editing_d, imp_q, imp_d, next_q, next_d;
  logic in_setup, next_rise, clr, inc_step, dec_step;
  assign in_setup = bus.rezhim == SETUP_MODE;
  assign next_rise = bus.btn_next & ~next_q;
  // Steps only count in EDIT, and a next edge wins over inc/dec.
  assign clr = (state_q != EDIT) | ~in_setup | next_rise;
  btn_step_gen
`ifdef SETUP_AUTOREPEAT_EN
    #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
`endif
    u_inc (.clock(clock), .reset(reset), .btn(bus.btn_inc), .clr(clr), .step(inc_step));
  btn_step_gen
`ifdef SETUP_AUTOREPEAT_EN
    #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
`endif
    u_dec (.clock(clock), .reset(reset), .btn(bus.btn_dec), .clr(clr), .step(dec_step));
  always_comb begin
    state_d = state_q;
    data_d = data_q;
    sel_d = sel_q;
    next_d = bus.btn_next;
    case (state_q)
      IDLE: if (in_setup) begin
        state_d = EDIT;
        data_d = bus.time_in;
        sel_d = '0;
      end
      EDIT: begin
        if (!in_setup) state_d = IDLE;
        else if (next_rise) begin
          state_d = sel_q == LAST ? COMMIT : EDIT;
          sel_d = sel_q == LAST ? sel_q : sel_q + SEL_W'(1);
        end else if (inc_step ^ dec_step)
          for (int i = 0; i < NUM_FIELDS; i++)
            if (SEL_W'(i) == sel_q)
              data_d[i*FIELD_W +: FIELD_W] = FIELD_W'(inc_step
                ? wrap_inc(32'(data_q[i*FIELD_W +: FIELD_W]), 32'(FIELD_MAX[i*FIELD_W +: FIELD_W]))
                : wrap_dec(32'(data_q[i*FIELD_W +: FIELD_W]), 32'(FIELD_MAX[i*FIELD_W +: FIELD_W])));
      end
      COMMIT: state_d = DONE;
      default: if (!in_setup) state_d = IDLE;
    endcase
    editing_d = state_d == EDIT;
    imp_d = state_d == COMMIT;
  end
  always_ff @(posedge clock)
    if (reset) begin
      state_q <= IDLE;
      data_q <= '0;
      sel_q <= '0;
      editing_q <= 1'b0;
      imp_q <= 1'b0;
      next_q <= 1'b1;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      sel_q <= sel_d;
      editing_q <= editing_d;
      imp_q <= imp_d;
      next_q <= next_d;
    end
  assign bus.setup_data = data_q;
  assign bus.field_sel = sel_q;
  assign bus.editing = editing_q;
  assign bus.setup_imp = imp_q;
endmodule

// File: tb/tb_time_setup_editor.sv
// tb_time_setup_editor: table-driven directed bench for time_setup_editor plus abort, overflow, reset-hold and hold-repeat sequences
module tb_time_setup_editor;
  typedef struct {
    logic [1:0] rz;
    logic nx, inc, dec;
    logic [23:0] data;
    logic [1:0] sel;
    logic edit, imp;
  } vec_t;
`ifdef SETUP_AUTOREPEAT_EN
  localparam logic [7:0] EXP_REP = 8'd6;
`else
  localparam logic [7:0] EXP_REP = 8'd1;
`endif
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int imp_cnt = 0;
  vec_t v[23];
  always #5 clock = ~clock;
  time_setup_editor_if bus ();
  time_setup_editor dut (.clock(clock), .reset(reset), .bus(bus));
  always @(posedge clock) if (bus.setup_imp) imp_cnt <= imp_cnt + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic drive(input logic [1:0] rz, input logic nx, input logic inc, input logic dec);
    bus.rezhim = rz;
    bus.btn_next = nx;
    bus.btn_inc = inc;
    bus.btn_dec = dec;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    v[0]  = '{2'd3, 1'b0, 1'b0, 1'b0, 24'h173B3A, 2'd0, 1'b1, 1'b0};
    v[1]  = '{2'd3, 1'b0, 1'b1, 1'b0, 24'h173B3B, 2'd0, 1'b1, 1'b0};
    v[2]  = '{2'd3, 1'b0, 1'b0, 1'b0, 24'h173B3B, 2'd0, 1'b1, 1'b0};
    v[3]  = '{2'd3, 1'b0, 1'b1, 1'b0, 24'h173B00, 2'd0, 1'b1, 1'b0};
    v[4]  = '{2'd3, 1'b0, 1'b0, 1'b1, 24'h173B3B, 2'd0, 1'b1, 1'b0};
    v[5]  = '{2'd3, 1'b0, 1'b0, 1'b0, 24'h173B3B, 2'd0, 1'b1, 1'b0};
    v[6]  = '{2'd3, 1'b0, 1'b1, 1'b1, 24'h173B3B, 2'd0, 1'b1, 1'b0};
    v[7]  = '{2'd3, 1'b0, 1'b0, 1'b0, 24'h173B3B, 2'd0, 1'b1, 1'b0};
    v[8]  = '{2'd3, 1'b1, 1'b1, 1'b0, 24'h173B3B, 2'd1, 1'b1, 1'b0};
    v[9]  = '{2'd3, 1'b0, 1'b0, 1'b0, 24'h173B3B, 2'd1, 1'b1, 1'b0};
    v[10] = '{2'd3, 1'b0, 1'b0, 1'b1, 24'h173A3B, 2'd1, 1'b1, 1'b0};
    v[11] = '{2'd3, 1'b0, 1'b0, 1'b0, 24'h173A3B, 2'd1, 1'b1, 1'b0};
    v[12] = '{2'd3, 1'b1, 1'b0, 1'b0, 24'h173A3B, 2'd2, 1'b1, 1'b0};
    v[13] = '{2'd3, 1'b0, 1'b0, 1'b0, 24'h173A3B, 2'd2, 1'b1, 1'b0};
    v[14] = '{2'd3, 1'b0, 1'b1, 1'b0, 24'h003A3B, 2'd2, 1'b1, 1'b0};
    v[15] = '{2'd3, 1'b0, 1'b0, 1'b0, 24'h003A3B, 2'd2, 1'b1, 1'b0};
    v[16] = '{2'd3, 1'b0, 1'b0, 1'b1, 24'h173A3B, 2'd2, 1'b1, 1'b0};
    v[17] = '{2'd3, 1'b0, 1'b0, 1'b0, 24'h173A3B, 2'd2, 1'b1, 1'b0};
    v[18] = '{2'd3, 1'b1, 1'b0, 1'b0, 24'h173A3B, 2'd2, 1'b0, 1'b1};
    v[19] = '{2'd3, 1'b0, 1'b0, 1'b0, 24'h173A3B, 2'd2, 1'b0, 1'b0};
    v[20] = '{2'd3, 1'b0, 1'b0, 1'b0, 24'h173A3B, 2'd2, 1'b0, 1'b0};
    v[21] = '{2'd3, 1'b0, 1'b1, 1'b0, 24'h173A3B, 2'd2, 1'b0, 1'b0};
    v[22] = '{2'd0, 1'b0, 1'b0, 1'b0, 24'h173A3B, 2'd2, 1'b0, 1'b0};
    drive(2'd0, 1'b0, 1'b0, 1'b0);
    bus.time_in = 24'h173B3A;
    tick(3);
    chk("reset_data", 32'(bus.setup_data), 32'h0);
    chk("reset_sel", 32'(bus.field_sel), 32'h0);
    chk("reset_edit", 32'(bus.editing), 32'h0);
    chk("reset_imp", 32'(bus.setup_imp), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 23; i++) begin
      drive(v[i].rz, v[i].nx, v[i].inc, v[i].dec);
      tick(1);
      chk($sformatf("vec%0d_data", i), 32'(bus.setup_data), 32'(v[i].data));
      chk($sformatf("vec%0d_sel", i), 32'(bus.field_sel), 32'(v[i].sel));
      chk($sformatf("vec%0d_edit", i), 32'(bus.editing), 32'(v[i].edit));
      chk($sformatf("vec%0d_imp", i), 32'(bus.setup_imp), 32'(v[i].imp));
    end
    chk("commit_pulses", 32'(imp_cnt), 32'd1);
    bus.time_in = 24'h0A141E;
    drive(2'd3, 1'b0, 1'b0, 1'b0);
    tick(1);
    chk("abort_load", 32'(bus.setup_data), 32'h0A141E);
    drive(2'd3, 1'b1, 1'b0, 1'b0);
    tick(1);
    drive(2'd3, 1'b0, 1'b1, 1'b0);
    tick(1);
    drive(2'd3, 1'b0, 1'b0, 1'b0);
    tick(1);
    chk("abort_edit_sel", 32'(bus.field_sel), 32'd1);
    chk("abort_edit_data", 32'(bus.setup_data), 32'h0A151E);
    drive(2'd0, 1'b0, 1'b0, 1'b0);
    tick(1);
    chk("abort_editing", 32'(bus.editing), 32'h0);
    chk("abort_held", 32'(bus.setup_data), 32'h0A151E);
    tick(3);
    chk("abort_no_imp", 32'(imp_cnt), 32'd1);
    drive(2'd3, 1'b0, 1'b0, 1'b0);
    tick(1);
    chk("reload_data", 32'(bus.setup_data), 32'h0A141E);
    chk("reload_sel", 32'(bus.field_sel), 32'd0);
    chk("reload_edit", 32'(bus.editing), 32'h1);
    drive(2'd0, 1'b0, 1'b0, 1'b0);
    tick(1);
    bus.time_in = 24'h173B50;
    drive(2'd3, 1'b0, 1'b0, 1'b0);
    tick(1);
    chk("over_load", 32'(bus.setup_data), 32'h173B50);
    drive(2'd3, 1'b0, 1'b1, 1'b0);
    tick(1);
    chk("over_inc_wrap", 32'(bus.setup_data), 32'h173B00);
    drive(2'd3, 1'b0, 1'b0, 1'b0);
    tick(1);
    drive(2'd3, 1'b0, 1'b1, 1'b0);
    bus.time_in = 24'h010203;
    reset = 1'b1;
    tick(2);
    chk("reset2_data", 32'(bus.setup_data), 32'h0);
    chk("reset2_edit", 32'(bus.editing), 32'h0);
    reset = 1'b0;
    tick(1);
    chk("held_load", 32'(bus.setup_data), 32'h010203);
    tick(3);
    chk("held_no_edge", 32'(bus.setup_data), 32'h010203);
    drive(2'd3, 1'b0, 1'b0, 1'b0);
    tick(1);
    drive(2'd3, 1'b0, 1'b1, 1'b0);
    tick(1);
    chk("held_release_press", 32'(bus.setup_data), 32'h010204);
    drive(2'd0, 1'b0, 1'b0, 1'b0);
    tick(1);
    bus.time_in = 24'h000000;
    drive(2'd3, 1'b0, 1'b0, 1'b0);
    tick(1);
    chk("rep_load", 32'(bus.setup_data), 32'h0);
    drive(2'd3, 1'b0, 1'b1, 1'b0);
    tick(100);
    drive(2'd3, 1'b0, 1'b0, 1'b0);
    tick(1);
    chk("rep_hold100", 32'(bus.setup_data), 32'(EXP_REP));
    chk("rep_sel", 32'(bus.field_sel), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
